// File: rtl/lsu_dmem_responder.sv
// Data-memory responder for the LSU load port with a store-buffer write port.
// Blocking single-load FSM with fixed latency over a word-organised XLEN-wide array.

package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{XLEN: 64, PLEN: 32};

    typedef enum logic [3:0] {
        LSU_LB  = 4'd0,
        LSU_LH  = 4'd1,
        LSU_LW  = 4'd2,
        LSU_LD  = 4'd3,
        LSU_LBU = 4'd4,
        LSU_LHU = 4'd5,
        LSU_LWU = 4'd6,
        LSU_SB  = 4'd7,
        LSU_SH  = 4'd8,
        LSU_SW  = 4'd9,
        LSU_SD  = 4'd10
    } lsu_op_e;

endpackage

// state  | meaning
// S_IDLE | ready for a load request
// S_WAIT | counting down the fixed load latency
// S_RSP  | response valid, waiting for the consumer
module lsu_dmem_responder
    import config_pkg::*;
#(
    parameter cfg_t                  Cfg       = EmptyCfg,
    parameter logic [Cfg.PLEN-1:0]   MEM_BASE  = 'h8000_0000,
    parameter int unsigned           MEM_WORDS = 4096,
    parameter int unsigned           LATENCY   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 ld_req_valid_i,
    output logic                 ld_req_ready_o,
    input  logic [Cfg.PLEN-1:0]  ld_req_addr_i,
    input  lsu_op_e              ld_req_op_i,
    output logic                 ld_rsp_valid_o,
    input  logic                 ld_rsp_ready_i,
    output logic [Cfg.XLEN-1:0]  ld_rsp_data_o,
    output logic                 ld_rsp_err_o,
    input  logic                 st_valid_i,
    input  logic [Cfg.PLEN-1:0]  st_addr_i,
    input  logic [Cfg.XLEN-1:0]  st_data_i,
    input  lsu_op_e              st_op_i,
    output logic                 st_err_o
);

    localparam int unsigned XLEN  = Cfg.XLEN;
    localparam int unsigned PLEN  = Cfg.PLEN;
    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(16);

    typedef logic [PLEN:0]       ext_addr_t;
    typedef logic [BYTES-1:0]    be_t;
    typedef logic [XLEN-1:0]     word_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    localparam ext_addr_t MEM_SPAN = ext_addr_t'(MEM_WORDS * BYTES);

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $error("lsu_dmem_responder: LATENCY must be within 1..15");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("lsu_dmem_responder: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(lsu_op_e op);
        logic [1:0] sz;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: sz = 2'd0;
            LSU_LH, LSU_LHU, LSU_SH: sz = 2'd1;
            LSU_LW, LSU_LWU, LSU_SW: sz = 2'd2;
            default:                 sz = 2'd3;
        endcase
        return sz;
    endfunction

    function automatic logic load_op_ok(lsu_op_e op);
        logic ok;
        case (op)
            LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU: ok = 1'b1;
            LSU_LD, LSU_LWU:                          ok = (XLEN == 64);
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic store_op_ok(lsu_op_e op);
        logic ok;
        case (op)
            LSU_SB, LSU_SH, LSU_SW: ok = 1'b1;
            LSU_SD:                 ok = (XLEN == 64);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(logic [2:0] lsb, logic [1:0] sz);
        logic bad;
        case (sz)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lsb[0];
            2'd2:    bad = |lsb[1:0];
            default: bad = |lsb;
        endcase
        return bad;
    endfunction

    word_t mem_q [MEM_WORDS];

    state_e            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    word_t             rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    ext_addr_t         ld_off;
    logic [IDX_W-1:0]  ld_idx;
    logic [OFF_W-1:0]  ld_boff;
    word_t             ld_raw;
    word_t             ld_ext;
    word_t             ld_data;
    logic              ld_fault;

    ext_addr_t         st_off;
    logic [IDX_W-1:0]  st_idx;
    logic [OFF_W-1:0]  st_boff;
    logic              st_fault;
    logic              st_we;
    be_t               st_be_base;
    be_t               st_be;
    word_t             st_wdata;

    // Load decode and extraction; the array read sees pre-edge contents.
    always_comb begin
        ld_off   = {1'b0, ld_req_addr_i} - {1'b0, MEM_BASE};
        ld_idx   = ld_off[OFF_W +: IDX_W];
        ld_boff  = ld_req_addr_i[OFF_W-1:0];
        ld_fault = (ld_off >= MEM_SPAN)
                 || misaligned(ld_req_addr_i[2:0], op_size(ld_req_op_i))
                 || !load_op_ok(ld_req_op_i);
        ld_raw   = mem_q[ld_idx] >> {ld_boff, 3'b000};
        case (ld_req_op_i)
            LSU_LB:  ld_ext = word_t'($signed(ld_raw[7:0]));
            LSU_LH:  ld_ext = word_t'($signed(ld_raw[15:0]));
            LSU_LW:  ld_ext = word_t'($signed(ld_raw[31:0]));
            LSU_LBU: ld_ext = word_t'(ld_raw[7:0]);
            LSU_LHU: ld_ext = word_t'(ld_raw[15:0]);
            LSU_LWU: ld_ext = word_t'(ld_raw[31:0]);
            default: ld_ext = ld_raw;
        endcase
        ld_data = ld_fault ? '0 : ld_ext;
    end

    always_comb begin
        st_off   = {1'b0, st_addr_i} - {1'b0, MEM_BASE};
        st_idx   = st_off[OFF_W +: IDX_W];
        st_boff  = st_addr_i[OFF_W-1:0];
        st_fault = (st_off >= MEM_SPAN)
                 || misaligned(st_addr_i[2:0], op_size(st_op_i))
                 || !store_op_ok(st_op_i);
        st_we    = st_valid_i && !st_fault;
        st_err_o = st_valid_i && st_fault;
        case (op_size(st_op_i))
            2'd0:    st_be_base = be_t'(8'h01);
            2'd1:    st_be_base = be_t'(8'h03);
            2'd2:    st_be_base = be_t'(8'h0F);
            default: st_be_base = be_t'(8'hFF);
        endcase
        st_be    = st_be_base << st_boff;
        st_wdata = st_data_i << {st_boff, 3'b000};
    end

    // Array contents survive reset on purpose.
    always_ff @(posedge clk_i) begin
        if (st_we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (st_be[b]) begin
                    mem_q[st_idx][8*b +: 8] <= st_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        ld_req_ready_o = (state_q == S_IDLE) && !flush_i;
        ld_rsp_valid_o = (state_q == S_RSP);

        case (state_q)
            S_IDLE: begin
                if (ld_req_valid_i && ld_req_ready_o) begin
                    rsp_data_d = ld_data;
                    rsp_err_d  = ld_fault;
                    cnt_d      = cnt_t'(LATENCY - 1);
                    state_d    = (LATENCY == 1) ? S_RSP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q > cnt_t'(1)) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (ld_rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign ld_rsp_data_o = rsp_data_q;
    assign ld_rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_lsu_dmem_responder.sv
// Self-checking bench for lsu_dmem_responder (XLEN=64, LATENCY=2) against a
// byte-addressed reference memory model.

module tb_lsu_dmem_responder;
    import config_pkg::*;

    localparam cfg_t        TB_CFG = '{XLEN: 64, PLEN: 32};
    localparam int unsigned LAT    = 2;
    localparam int unsigned WORDS  = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        ld_req_valid_i = 1'b0;
    logic        ld_req_ready_o;
    logic [31:0] ld_req_addr_i = '0;
    lsu_op_e     ld_req_op_i = LSU_LB;
    logic        ld_rsp_valid_o;
    logic        ld_rsp_ready_i = 1'b1;
    logic [63:0] ld_rsp_data_o;
    logic        ld_rsp_err_o;
    logic        st_valid_i = 1'b0;
    logic [31:0] st_addr_i = '0;
    logic [63:0] st_data_i = '0;
    lsu_op_e     st_op_i = LSU_SB;
    logic        st_err_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [int unsigned];

    lsu_dmem_responder #(
        .Cfg       (TB_CFG),
        .MEM_BASE  (BASE),
        .MEM_WORDS (WORDS),
        .LATENCY   (LAT)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .ld_req_valid_i (ld_req_valid_i),
        .ld_req_ready_o (ld_req_ready_o),
        .ld_req_addr_i  (ld_req_addr_i),
        .ld_req_op_i    (ld_req_op_i),
        .ld_rsp_valid_o (ld_rsp_valid_o),
        .ld_rsp_ready_i (ld_rsp_ready_i),
        .ld_rsp_data_o  (ld_rsp_data_o),
        .ld_rsp_err_o   (ld_rsp_err_o),
        .st_valid_i     (st_valid_i),
        .st_addr_i      (st_addr_i),
        .st_data_i      (st_data_i),
        .st_op_i        (st_op_i),
        .st_err_o       (st_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void op_info(input lsu_op_e op, output int n, output bit sgn,
                                    output bit isld, output bit isst);
        n = 8; sgn = 0; isld = 0; isst = 0;
        case (op)
            LSU_LB:  begin n = 1; sgn = 1; isld = 1; end
            LSU_LH:  begin n = 2; sgn = 1; isld = 1; end
            LSU_LW:  begin n = 4; sgn = 1; isld = 1; end
            LSU_LD:  begin n = 8; isld = 1; end
            LSU_LBU: begin n = 1; isld = 1; end
            LSU_LHU: begin n = 2; isld = 1; end
            LSU_LWU: begin n = 4; isld = 1; end
            LSU_SB:  begin n = 1; isst = 1; end
            LSU_SH:  begin n = 2; isst = 1; end
            LSU_SW:  begin n = 4; isst = 1; end
            LSU_SD:  begin n = 8; isst = 1; end
            default: ;
        endcase
    endfunction

    function automatic bit addr_bad(input logic [31:0] a, input int n);
        longint unsigned la = longint'(a);
        return (la < longint'(BASE)) || (la >= longint'(BASE) + WORDS * 8) || ((a % n) != 0);
    endfunction

    function automatic void model_load(input logic [31:0] a, input lsu_op_e op,
                                       output logic [63:0] d, output logic e);
        int n; bit sgn, isld, isst;
        op_info(op, n, sgn, isld, isst);
        e = !isld || addr_bad(a, n);
        d = '0;
        if (!e) begin
            for (int i = 0; i < n; i++) d = d | (64'(ref_mem[a + i]) << (8 * i));
            if (sgn && d[8*n-1]) d = d | ~((64'd1 << (8 * n)) - 64'd1);
        end
    endfunction

    function automatic bit model_st_err(input logic [31:0] a, input lsu_op_e op);
        int n; bit sgn, isld, isst;
        op_info(op, n, sgn, isld, isst);
        return !isst || addr_bad(a, n);
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [63:0] d, input lsu_op_e op);
        int n; bit sgn, isld, isst;
        op_info(op, n, sgn, isld, isst);
        for (int i = 0; i < n; i++) ref_mem[a + i] = d[8*i +: 8];
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [63:0] d, input lsu_op_e op,
                            input string name);
        bit ee;
        @(negedge clk_i);
        st_valid_i = 1; st_addr_i = a; st_data_i = d; st_op_i = op;
        #1;
        ee = model_st_err(a, op);
        checks++;
        if (st_err_o !== ee) begin
            errors++;
            $display("FAIL %s st_err: got %b want %b", name, st_err_o, ee);
        end
        @(posedge clk_i);
        if (!ee) model_store(a, d, op);
        #1 st_valid_i = 0;
    endtask

    task automatic do_load(input logic [31:0] a, input lsu_op_e op, input string name,
                           input bit with_st = 0, input logic [31:0] sa = '0,
                           input logic [63:0] sd = '0, input lsu_op_e sop = LSU_SD);
        logic [63:0] ed; logic ee; int k;
        @(negedge clk_i);
        ld_req_valid_i = 1; ld_req_addr_i = a; ld_req_op_i = op; ld_rsp_ready_i = 1;
        if (with_st) begin
            st_valid_i = 1; st_addr_i = sa; st_data_i = sd; st_op_i = sop;
        end
        model_load(a, op, ed, ee);
        checks++;
        if (ld_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready: got %b want 1", name, ld_req_ready_o);
        end
        @(posedge clk_i);
        if (with_st && !model_st_err(sa, sop)) model_store(sa, sd, sop);
        #1 ld_req_valid_i = 0; st_valid_i = 0;
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (ld_rsp_valid_o !== 1'b1 && k < 20);
        checks++;
        if (k != LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, k, LAT);
        end
        checks++;
        if (ld_rsp_data_o !== ed) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, ld_rsp_data_o, ed);
        end
        checks++;
        if (ld_rsp_err_o !== ee) begin
            errors++;
            $display("FAIL %s err: got %b want %b", name, ld_rsp_err_o, ee);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks += 4;
        if (ld_req_ready_o !== 1'b1) begin errors++; $display("FAIL reset ready: got %b want 1", ld_req_ready_o); end
        if (ld_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", ld_rsp_valid_o); end
        if (ld_rsp_data_o !== 64'h0) begin errors++; $display("FAIL reset data: got %h want 0", ld_rsp_data_o); end
        if (ld_rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", ld_rsp_err_o); end
        @(negedge clk_i);
        rst_ni = 1;
        for (int w = 0; w < 8; w++)
            do_store(BASE + 32'(8 * w), {$urandom, $urandom}, LSU_SD, "init_sd");
    endtask

    task automatic test_extract();
        do_store(BASE, 64'h1122334455667788, LSU_SD, "ext_sd");
        do_load(BASE + 32'h7, LSU_LB,  "ext_lb7");
        do_load(BASE,         LSU_LB,  "ext_lb0");
        do_load(BASE + 32'h2, LSU_LHU, "ext_lhu2");
        do_load(BASE + 32'h4, LSU_LW,  "ext_lw4");
        do_load(BASE + 32'h6, LSU_LH,  "ext_lh6");
        do_load(BASE + 32'h4, LSU_LWU, "ext_lwu4");
    endtask

    task automatic test_faults();
        do_load(32'h7FFF_FFFC, LSU_LW, "flt_lw_below");
        do_load(32'h8000_8000, LSU_LD, "flt_ld_above");
        do_load(32'h8000_7FF8, LSU_LD, "flt_ld_last");
        do_load(BASE + 32'h1, LSU_LH, "flt_lh_mis");
        do_load(BASE, LSU_SW, "flt_store_op");
        do_store(BASE + 32'h2, 64'hCAFEF00D, LSU_SW, "flt_sw_mis");
        do_store(BASE, 64'hCAFEF00D, LSU_LW, "flt_load_op");
        do_load(BASE, LSU_LD, "flt_unchanged");
    endtask

    task automatic test_stall();
        logic [63:0] ed, d0; logic ee; int k;
        @(negedge clk_i);
        ld_req_valid_i = 1; ld_req_addr_i = BASE; ld_req_op_i = LSU_LD; ld_rsp_ready_i = 0;
        model_load(BASE, LSU_LD, ed, ee);
        @(posedge clk_i);
        #1 ld_req_valid_i = 0;
        k = 0;
        do begin @(negedge clk_i); k++; end while (ld_rsp_valid_o !== 1'b1 && k < 20);
        checks += 2;
        if (k != LAT) begin errors++; $display("FAIL stall latency: got %0d want %0d", k, LAT); end
        if (ld_rsp_data_o !== ed) begin errors++; $display("FAIL stall data: got %h want %h", ld_rsp_data_o, ed); end
        d0 = ld_rsp_data_o;
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk_i);
            checks += 3;
            if (ld_rsp_valid_o !== 1'b1) begin errors++; $display("FAIL stall valid c%0d: got %b want 1", c, ld_rsp_valid_o); end
            if (ld_rsp_data_o !== d0) begin errors++; $display("FAIL stall hold c%0d: got %h want %h", c, ld_rsp_data_o, d0); end
            if (ld_req_ready_o !== 1'b0) begin errors++; $display("FAIL stall req_ready c%0d: got %b want 0", c, ld_req_ready_o); end
        end
        ld_rsp_ready_i = 1;
        @(negedge clk_i);
        checks += 2;
        if (ld_req_ready_o !== 1'b1) begin errors++; $display("FAIL stall ready_after: got %b want 1", ld_req_ready_o); end
        if (ld_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL stall valid_after: got %b want 0", ld_rsp_valid_o); end
    endtask

    task automatic test_flush();
        int rose;
        @(negedge clk_i);
        ld_req_valid_i = 1; ld_req_addr_i = BASE + 32'h8; ld_req_op_i = LSU_LD;
        @(negedge clk_i);
        flush_i = 1;
        #1;
        checks++;
        if (ld_req_ready_o !== 1'b0) begin errors++; $display("FAIL flush ready_in_flush: got %b want 0", ld_req_ready_o); end
        @(negedge clk_i);
        flush_i = 0; ld_req_valid_i = 0;
        #1;
        checks++;
        if (ld_req_ready_o !== 1'b1) begin errors++; $display("FAIL flush ready_after: got %b want 1", ld_req_ready_o); end
        rose = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (ld_rsp_valid_o !== 1'b0) rose++;
        end
        checks++;
        if (rose != 0) begin errors++; $display("FAIL flush no_rsp: got %0d valid cycles want 0", rose); end
    endtask

    task automatic test_same_cycle();
        do_store(BASE + 32'h10, 64'h0, LSU_SD, "same_zero");
        do_load(BASE + 32'h10, LSU_LD, "same_old", 1, BASE + 32'h10, 64'hDEAD, LSU_SD);
        do_load(BASE + 32'h10, LSU_LD, "same_new");
    endtask

    task automatic test_back_to_back();
        int hs [$];
        logic [63:0] ed; logic ee;
        logic [31:0] a = BASE + 32'(8 * $urandom_range(0, 7));
        model_load(a, LSU_LD, ed, ee);
        @(negedge clk_i);
        ld_req_valid_i = 1; ld_req_addr_i = a; ld_req_op_i = LSU_LD; ld_rsp_ready_i = 1;
        for (int c = 0; c < 14; c++) begin
            if (ld_req_ready_o === 1'b1) hs.push_back(c);
            if (ld_rsp_valid_o === 1'b1) begin
                checks++;
                if (ld_rsp_data_o !== ed) begin errors++; $display("FAIL b2b data c%0d: got %h want %h", c, ld_rsp_data_o, ed); end
            end
            @(negedge clk_i);
        end
        ld_req_valid_i = 0;
        checks++;
        if (hs.size() < 3) begin errors++; $display("FAIL b2b count: got %0d want >=3", hs.size()); end
        for (int i = 1; i < hs.size(); i++) begin
            checks++;
            if (hs[i] - hs[i-1] != int'(LAT) + 1) begin
                errors++;
                $display("FAIL b2b gap%0d: got %0d want %0d", i, hs[i] - hs[i-1], LAT + 1);
            end
        end
        // drain the last accepted request
        repeat (LAT + 2) @(negedge clk_i);
    endtask

    task automatic test_random();
        logic [31:0] a; lsu_op_e op;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? BASE - 32'($urandom_range(1, 16))
                                                : BASE + 32'h8000 + 32'($urandom_range(0, 16));
            else
                a = BASE + 32'($urandom_range(0, 63));
            op = lsu_op_e'(4'($urandom_range(0, 10)));
            if ($urandom_range(0, 2) == 0) do_store(a, {$urandom, $urandom}, op, "rnd_st");
            else                           do_load(a, op, "rnd_ld");
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] ed; logic ee; int k;
        do_store(BASE + 32'h18, 64'hA5A5_0F0F_1234_8765, LSU_SD, "rst_sd");
        @(negedge clk_i);
        ld_req_valid_i = 1; ld_req_addr_i = BASE + 32'h18; ld_req_op_i = LSU_LD; ld_rsp_ready_i = 0;
        @(posedge clk_i);
        #1 ld_req_valid_i = 0;
        k = 0;
        do begin @(negedge clk_i); k++; end while (ld_rsp_valid_o !== 1'b1 && k < 20);
        #2 rst_ni = 0;
        #1;
        checks += 4;
        if (ld_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid valid: got %b want 0", ld_rsp_valid_o); end
        if (ld_rsp_data_o !== 64'h0) begin errors++; $display("FAIL rst_mid data: got %h want 0", ld_rsp_data_o); end
        if (ld_rsp_err_o !== 1'b0) begin errors++; $display("FAIL rst_mid err: got %b want 0", ld_rsp_err_o); end
        if (ld_req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid ready: got %b want 1", ld_req_ready_o); end
        @(negedge clk_i);
        rst_ni = 1; ld_rsp_ready_i = 1;
        model_load(BASE + 32'h18, LSU_LD, ed, ee);
        do_load(BASE + 32'h18, LSU_LD, "rst_mem_kept");
    endtask

    initial begin
        test_reset();
        test_extract();
        test_faults();
        test_stall();
        test_flush();
        test_same_cycle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
